// File: rtl/capture_buffer_if.sv
// Bus bundle between the capture buffer, its upstream FWFT FIFO and the readout consumer.
interface capture_buffer_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 10
);
   // Upstream FIFO side
   logic                data_in_empty;
   logic [DATA_W-1:0]   data_in;
   logic                data_read;
   // Control
   logic                mode;
   logic                zero;
   // Readout side
   logic                rd_en;
   logic                valid;
   logic [DATA_W-1:0]   data_out;
   logic                dout_valid;
   // Status
   logic [ADDR_W:0]     count;
   logic [ADDR_W:0]     fill;
   logic                full;
   logic                overflow;

   // Buffer side
   modport slave (
      input  data_in_empty, data_in, mode, zero, rd_en,
      output data_read, valid, data_out, dout_valid, count, fill, full, overflow
   );

   // Host / consumer side
   modport master (
      output data_in_empty, data_in, mode, zero, rd_en,
      input  data_read, valid, data_out, dout_valid, count, fill, full, overflow
   );
endinterface

// File: rtl/capture_buffer.sv
// Capture/replay buffer: drains an FWFT FIFO into a dual-port RAM, one-shot or circular,
// with rewind, occupancy reporting and a sticky overflow flag.
module capture_buffer #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 10
) (
   input  logic               clk,
   input  logic               rst,
   capture_buffer_if.slave    bus
);
   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;

   logic [DATA_W-1:0] r_mem [DEPTH];

   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [CNT_W-1:0]  r_fill;
   logic              r_full;
   logic              r_overflow;
   logic [DATA_W-1:0] r_data_out;
   logic              r_dout_valid;

   logic              w_wr;
   logic              w_rd;
   logic              w_drop;
   logic [ADDR_W-1:0] w_wr_ptr_next;
   logic [ADDR_W-1:0] w_rd_ptr_next;
   logic [CNT_W-1:0]  w_fill_next;
   logic [CNT_W-1:0]  w_count_next;
   logic              w_overflow_next;

   // Next-state for pointers and occupancy; a drop is a circular write over an unread oldest word.
   always_comb begin
      w_wr            = ~rst & ~bus.data_in_empty & (bus.mode | ~r_full);
      w_rd            = bus.rd_en & (r_count != '0) & ~bus.zero;
      w_drop          = w_wr & r_full & (r_count == CNT_W'(DEPTH)) & ~w_rd;
      w_wr_ptr_next   = r_wr_ptr + ADDR_W'(w_wr);
      w_fill_next     = r_fill + CNT_W'(w_wr & ~r_full);
      w_rd_ptr_next   = r_rd_ptr;
      w_count_next    = r_count;
      w_overflow_next = r_overflow;
      if (bus.zero) begin
         w_rd_ptr_next   = w_wr_ptr_next - ADDR_W'(w_fill_next);
         w_count_next    = w_fill_next;
         w_overflow_next = 1'b0;
      end else begin
         if (w_rd | w_drop) begin
            w_rd_ptr_next = r_rd_ptr + ADDR_W'(1);
         end
         if (w_wr & ~w_rd & ~w_drop) begin
            w_count_next = r_count + CNT_W'(1);
         end else if (w_rd & ~w_wr) begin
            w_count_next = r_count - CNT_W'(1);
         end
         if (w_drop) begin
            w_overflow_next = 1'b1;
         end
      end
   end

   // Control and status registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_fill     <= '0;
         r_full     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_wr_ptr   <= w_wr_ptr_next;
         r_rd_ptr   <= w_rd_ptr_next;
         r_count    <= w_count_next;
         r_fill     <= w_fill_next;
         r_full     <= (w_fill_next == CNT_W'(DEPTH));
         r_overflow <= w_overflow_next;
      end
   end

   // RAM write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= data_in_word();
      end
   end

   // Registered read port, read-first on a same-address write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data_out   <= '0;
         r_dout_valid <= 1'b0;
      end else begin
         r_dout_valid <= w_rd;
         if (w_rd) begin
            r_data_out <= r_mem[r_rd_ptr];
         end
      end
   end

   function automatic logic [DATA_W-1:0] data_in_word();
      return bus.data_in;
   endfunction

   assign bus.data_read  = w_wr;
   assign bus.valid      = (r_count != '0);
   assign bus.data_out   = r_data_out;
   assign bus.dout_valid = r_dout_valid;
   assign bus.count      = r_count;
   assign bus.fill       = r_fill;
   assign bus.full       = r_full;
   assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_capture_buffer.sv
// Directed bench for capture_buffer with a queue-based reference model checked every cycle.
module tb_capture_buffer;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 4;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   capture_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   capture_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Upstream FWFT FIFO: bench pushes at up_wr, model pops at up_rd.
   logic [31:0] up_mem [256];
   logic [7:0]  up_wr = '0;
   logic [7:0]  up_rd = '0;
   assign bus.data_in_empty = (up_wr == up_rd);
   assign bus.data_in       = up_mem[up_rd];

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: retained words oldest-first, plus number of unread ones at the tail.
   logic [31:0] m_ret [$];
   int          m_cnt = 0;
   bit          m_ovf = 1'b0;
   logic [31:0] m_dout = '0;
   bit          m_dv = 1'b0;

   always @(posedge clk or posedge rst) begin
      bit m_wr, m_rd;
      if (rst) begin
         m_ret.delete();
         m_cnt  = 0;
         m_ovf  = 1'b0;
         m_dout = '0;
         m_dv   = 1'b0;
         if (clk === 1'b1) up_rd <= up_wr;
      end else begin
         m_wr = !bus.data_in_empty && (bus.mode || m_ret.size() < DEPTH);
         m_rd = bus.rd_en && m_cnt > 0 && !bus.zero;
         m_dv = m_rd;
         if (m_rd) begin
            m_dout = m_ret[m_ret.size() - m_cnt];
            m_cnt--;
         end
         if (m_wr) begin
            if (m_ret.size() == DEPTH) begin
               void'(m_ret.pop_front());
               if (m_cnt == DEPTH) m_ovf = 1'b1;
               else m_cnt++;
            end else begin
               m_cnt++;
            end
            m_ret.push_back(bus.data_in);
            up_rd <= up_rd + 8'd1;
         end
         if (bus.zero) begin
            m_cnt = m_ret.size();
            m_ovf = 1'b0;
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (!rst) begin
         check("data_read", 32'(bus.data_read),
               32'(!bus.data_in_empty && (bus.mode || m_ret.size() < DEPTH)));
         check("valid",      32'(bus.valid),      32'(m_cnt != 0));
         check("count",      32'(bus.count),      32'(m_cnt));
         check("fill",       32'(bus.fill),       32'(m_ret.size()));
         check("full",       32'(bus.full),       32'(m_ret.size() == DEPTH));
         check("overflow",   32'(bus.overflow),   32'(m_ovf));
         check("dout_valid", 32'(bus.dout_valid), 32'(m_dv));
         check("data_out",   bus.data_out,        m_dout);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] w);
      up_mem[up_wr] = w;
      up_wr = up_wr + 8'd1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   // Back-to-back reads with literal expected words base, base+1, ...
   task automatic read_n(input logic [31:0] base, input int n);
      bus.rd_en = 1'b1;
      for (int i = 0; i < n; i++) begin
         step();
         check("rd_dv", 32'(bus.dout_valid), 32'd1);
         check("rd_word", bus.data_out, base + 32'(i));
      end
      bus.rd_en = 1'b0;
   endtask

   initial begin
      bus.mode  = 1'b0;
      bus.zero  = 1'b0;
      bus.rd_en = 1'b0;
      step();
      check("rst_count", 32'(bus.count), 32'd0);
      check("rst_valid", 32'(bus.valid), 32'd0);
      check("rst_data_read", 32'(bus.data_read), 32'd0);
      step();
      rst = 1'b0;

      // One-shot: 20 offered, 16 taken.
      for (int i = 0; i < 20; i++) push(32'h100 + 32'(i));
      repeat (20) step();
      check("m0_fill", 32'(bus.fill), 32'd16);
      check("m0_count", 32'(bus.count), 32'd16);
      check("m0_full", 32'(bus.full), 32'd1);
      check("m0_blocked", 32'(bus.data_read), 32'd0);
      check("m0_upstream_left", 32'(up_wr - up_rd), 32'd4);
      read_n(32'h100, 16);
      step();
      check("m0_count_end", 32'(bus.count), 32'd0);
      check("m0_valid_end", 32'(bus.valid), 32'd0);

      // One-shot replay.
      bus.zero = 1'b1;
      step();
      bus.zero = 1'b0;
      check("replay_count", 32'(bus.count), 32'd16);
      read_n(32'h100, 16);
      check("replay_ovf", 32'(bus.overflow), 32'd0);

      // Circular wrap.
      bus.mode = 1'b1;
      do_reset();
      for (int i = 0; i < 20; i++) push(32'h200 + 32'(i));
      repeat (22) step();
      check("m1_fill", 32'(bus.fill), 32'd16);
      check("m1_count", 32'(bus.count), 32'd16);
      check("m1_ovf", 32'(bus.overflow), 32'd1);
      read_n(32'h204, 16);
      bus.rd_en = 1'b1;
      step();
      bus.rd_en = 1'b0;
      check("m1_extra_rd_dv", 32'(bus.dout_valid), 32'd0);
      check("m1_extra_rd_hold", bus.data_out, 32'h213);

      // Circular full with concurrent read and write.
      bus.zero = 1'b1;
      step();
      bus.zero = 1'b0;
      check("conc_count_pre", 32'(bus.count), 32'd16);
      push(32'h2AA);
      bus.rd_en = 1'b1;
      step();
      bus.rd_en = 1'b0;
      check("conc_word", bus.data_out, 32'h204);
      check("conc_count", 32'(bus.count), 32'd16);
      check("conc_ovf", 32'(bus.overflow), 32'd0);
      step();

      // zero + rd_en + write on one edge.
      bus.mode = 1'b0;
      do_reset();
      for (int i = 0; i < 5; i++) push(32'h400 + 32'(i));
      repeat (6) step();
      read_n(32'h400, 3);
      check("zrw_count_pre", 32'(bus.count), 32'd2);
      push(32'h405);
      bus.zero  = 1'b1;
      bus.rd_en = 1'b1;
      step();
      bus.zero  = 1'b0;
      bus.rd_en = 1'b0;
      check("zrw_dv", 32'(bus.dout_valid), 32'd0);
      check("zrw_count", 32'(bus.count), 32'd6);
      check("zrw_fill", 32'(bus.fill), 32'd6);
      read_n(32'h400, 6);

      // Asynchronous reset mid-burst.
      bus.mode = 1'b1;
      for (int i = 0; i < 12; i++) push(32'h500 + 32'(i));
      bus.rd_en = 1'b1;
      repeat (5) step();
      #5;
      rst = 1'b1;
      #1;
      check("arst_data_read", 32'(bus.data_read), 32'd0);
      check("arst_valid", 32'(bus.valid), 32'd0);
      check("arst_count", 32'(bus.count), 32'd0);
      check("arst_fill", 32'(bus.fill), 32'd0);
      check("arst_full", 32'(bus.full), 32'd0);
      check("arst_ovf", 32'(bus.overflow), 32'd0);
      check("arst_dv", 32'(bus.dout_valid), 32'd0);
      check("arst_dout", bus.data_out, 32'd0);
      bus.rd_en = 1'b0;
      step();
      rst = 1'b0;
      push(32'h3A5);
      step();
      bus.rd_en = 1'b1;
      step();
      bus.rd_en = 1'b0;
      check("post_rst_dv", 32'(bus.dout_valid), 32'd1);
      check("post_rst_word", bus.data_out, 32'h3A5);
      repeat (2) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
